// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, state, ALU and mux-select constants for the cpu
package cpu_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic ADR_PC     = 1'b0;
  localparam logic ADR_RESULT = 1'b1;

  // Sign-extended immediate; B and J forms always have bit 0 clear.
  function automatic logic [31:0] imm_ext(input logic [31:7] instr, input logic [1:0] src);
    case (src)
      IMM_I:   imm_ext = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm_ext = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm_ext = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      default: imm_ext = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    endcase
  endfunction

endpackage

// File: rtl/cpu_if.sv
// rtl/cpu_if.sv - unified memory bus between the datapath and the memory
interface cpu_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;

  modport master (output addr, output wdata, output we, input rdata);
  modport slave  (input addr, input wdata, input we, output rdata);
endinterface

// File: rtl/cpu_alu.sv
// rtl/cpu_alu.sv - 32-bit ALU with add/sub/and/or/signed slt
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [2:0]  ctl_i,
  output logic [31:0] y_o,
  output logic        zero_o
);

  // Operation select; unused encodings produce zero.
  always_comb begin
    y_o = '0;
    case (ctl_i)
      ALU_ADD: y_o = a_i + b_i;
      ALU_SUB: y_o = a_i - b_i;
      ALU_AND: y_o = a_i & b_i;
      ALU_OR:  y_o = a_i | b_i;
      ALU_SLT: y_o = {31'b0, ($signed(a_i) < $signed(b_i))};
      default: y_o = '0;
    endcase
  end

  assign zero_o = (y_o == 32'h0);

endmodule

// File: rtl/cpu_control.sv
// rtl/cpu_control.sv - control unit: main FSM plus ALU and immediate decoders
module cpu_control
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       zero_i,
  output logic       pc_write_o,
  output logic       ir_write_o,
  output logic       reg_write_o,
  output logic       mem_write_o,
  output logic       adr_src_o,
  output logic [1:0] result_src_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [2:0] alu_control_o,
  output logic [1:0] imm_src_o
);

  logic       Branch;
  logic       pc_update;
  logic [1:0] alu_op;
  logic [1:0] ImmSrc;

  cpu_fsm fsm (
    .clk         (clk),
    .reset       (reset),
    .op_i        (op_i),
    .ir_write_o  (ir_write_o),
    .pc_update_o (pc_update),
    .reg_write_o (reg_write_o),
    .mem_write_o (mem_write_o),
    .branch_o    (Branch),
    .adr_src_o   (adr_src_o),
    .result_src_o(result_src_o),
    .alu_src_a_o (alu_src_a_o),
    .alu_src_b_o (alu_src_b_o),
    .alu_op_o    (alu_op)
  );

  assign pc_write_o = pc_update | (Branch & zero_i);
  assign imm_src_o  = ImmSrc;

  // ALU decoder; only R-type with funct7[5] subtracts, never addi.
  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control_o = ALU_ADD;
      ALUOP_SUB: alu_control_o = ALU_SUB;
      default: begin
        case (funct3_i)
          3'b000:  alu_control_o = (op_i[5] && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control_o = ALU_SLT;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: alu_control_o = ALU_ADD;
        endcase
      end
    endcase
  end

  // Immediate format select from the opcode.
  always_comb begin
    ImmSrc = IMM_I;
    case (op_i)
      OP_SW:   ImmSrc = IMM_S;
      OP_BEQ:  ImmSrc = IMM_B;
      OP_JAL:  ImmSrc = IMM_J;
      default: ImmSrc = IMM_I;
    endcase
  end

endmodule

// File: rtl/cpu_fsm.sv
// rtl/cpu_fsm.sv - multi-cycle main controller state machine
module cpu_fsm
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op_i,
  output logic       ir_write_o,
  output logic       pc_update_o,
  output logic       reg_write_o,
  output logic       mem_write_o,
  output logic       branch_o,
  output logic       adr_src_o,
  output logic [1:0] result_src_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o
);

  state_t     cs, ns;
  logic [1:0] ALUOp;

  assign alu_op_o = ALUOp;

  // State register; reset always lands in FETCH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cs <= S_FETCH;
    else        cs <= ns;
  end

  // Next state and per-state control outputs.
  always_comb begin
    ns           = S_FETCH;
    ir_write_o   = 1'b0;
    pc_update_o  = 1'b0;
    reg_write_o  = 1'b0;
    mem_write_o  = 1'b0;
    branch_o     = 1'b0;
    adr_src_o    = ADR_PC;
    result_src_o = RES_ALUOUT;
    alu_src_a_o  = SRCA_PC;
    alu_src_b_o  = SRCB_RS2;
    ALUOp        = ALUOP_ADD;
    case (cs)
      S_FETCH: begin
        ir_write_o   = 1'b1;
        pc_update_o  = 1'b1;
        alu_src_b_o  = SRCB_FOUR;
        result_src_o = RES_ALURES;
        ns           = S_DECODE;
      end
      S_DECODE: begin
        // OldPC+imm is precomputed here so beq/jal find their target in alu_out.
        alu_src_a_o = SRCA_OLDPC;
        alu_src_b_o = SRCB_IMM;
        case (op_i)
          OP_LW, OP_SW: ns = S_MEMADR;
          OP_R:         ns = S_EXECUTER;
          OP_I:         ns = S_EXECUTEI;
          OP_BEQ:       ns = S_BEQ;
          OP_JAL:       ns = S_JAL;
          default:      ns = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alu_src_a_o = SRCA_RS1;
        alu_src_b_o = SRCB_IMM;
        ns          = (op_i == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src_o = ADR_RESULT;
        ns        = S_MEMWB;
      end
      S_MEMWB: begin
        result_src_o = RES_DATA;
        reg_write_o  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src_o   = ADR_RESULT;
        mem_write_o = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a_o = SRCA_RS1;
        ALUOp       = ALUOP_FUNCT;
        ns          = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a_o = SRCA_RS1;
        alu_src_b_o = SRCB_IMM;
        ALUOp       = ALUOP_FUNCT;
        ns          = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_o = 1'b1;
      end
      S_BEQ: begin
        alu_src_a_o = SRCA_RS1;
        ALUOp       = ALUOP_SUB;
        branch_o    = 1'b1;
      end
      S_JAL: begin
        // PC takes the target from alu_out while the ALU forms the link value.
        alu_src_a_o = SRCA_OLDPC;
        alu_src_b_o = SRCB_FOUR;
        pc_update_o = 1'b1;
        ns          = S_ALUWB;
      end
      default: ns = S_FETCH;
    endcase
  end

endmodule

// File: rtl/cpu_mem.sv
// rtl/cpu_mem.sv - unified instruction/data memory, combinational read, sync write
module cpu_mem #(
  parameter int MEM_WORDS = 256
) (
  input logic  clk,
  cpu_if.slave bus
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  logic [31:0]   mem [MEM_WORDS];
  logic [AW-1:0] idx;
  logic          unused_byte_offset;

  // Byte address to word index, wrapping modulo the memory depth.
  assign idx                = AW'(bus.addr[31:2] % 30'(MEM_WORDS));
  assign unused_byte_offset = ^bus.addr[1:0];
  assign bus.rdata          = mem[idx];

  // Contents have no reset so a preloaded program survives reset.
  always_ff @(posedge clk) begin
    if (bus.we) mem[idx] <= bus.wdata;
  end

endmodule

// File: rtl/cpu_regfile.sv
// rtl/cpu_regfile.sv - 32x32 register file, two async reads, one sync write, x0 hardwired
module cpu_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  input  logic [4:0]  wa_i,
  input  logic        we_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o
);

  logic [31:0] regs [0:31];

  // Reset clears every register; writes aimed at x0 are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we_i && (wa_i != 5'd0)) begin
      regs[wa_i] <= wd_i;
    end
  end

  assign rd1_o = (ra1_i == 5'd0) ? 32'h0 : regs[ra1_i];
  assign rd2_o = (ra2_i == 5'd0) ? 32'h0 : regs[ra2_i];

endmodule

// File: rtl/cpu.sv
// rtl/cpu.sv - multi-cycle RV32I-subset processor top with unified memory
module cpu
  import cpu_pkg::*;
#(
  parameter int MEM_WORDS = 256
) (
  input logic clk,
  input logic reset
);

  logic [31:0] pc_out, ir_out, alu_out, oldpc_q, data_q, a_q, b_q;
  logic        PCwrite, RegWrite, MemWrite, IRWrite, AdrSrc, zero;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, imm_src;
  logic [2:0]  ALUControl;
  logic [31:0] SrcA, SrcB, alu_res, Result, imm_val, rd1, rd2;

  cpu_if mem_bus ();

  assign mem_bus.addr  = (AdrSrc == ADR_RESULT) ? Result : pc_out;
  assign mem_bus.wdata = b_q;
  assign mem_bus.we    = MemWrite;
  assign imm_val       = imm_ext(ir_out[31:7], imm_src);

  cpu_control control_unit (
    .clk          (clk),
    .reset        (reset),
    .op_i         (ir_out[6:0]),
    .funct3_i     (ir_out[14:12]),
    .funct7b5_i   (ir_out[30]),
    .zero_i       (zero),
    .pc_write_o   (PCwrite),
    .ir_write_o   (IRWrite),
    .reg_write_o  (RegWrite),
    .mem_write_o  (MemWrite),
    .adr_src_o    (AdrSrc),
    .result_src_o (ResultSrc),
    .alu_src_a_o  (ALUSrcA),
    .alu_src_b_o  (ALUSrcB),
    .alu_control_o(ALUControl),
    .imm_src_o    (imm_src)
  );

  cpu_regfile regfile_inst (
    .clk  (clk),
    .reset(reset),
    .ra1_i(ir_out[19:15]),
    .ra2_i(ir_out[24:20]),
    .wa_i (ir_out[11:7]),
    .we_i (RegWrite),
    .wd_i (Result),
    .rd1_o(rd1),
    .rd2_o(rd2)
  );

  cpu_mem #(.MEM_WORDS(MEM_WORDS)) memory (
    .clk(clk),
    .bus(mem_bus)
  );

  cpu_alu alu (
    .a_i   (SrcA),
    .b_i   (SrcB),
    .ctl_i (ALUControl),
    .y_o   (alu_res),
    .zero_o(zero)
  );

  // ALU operand A select.
  always_comb begin
    SrcA = pc_out;
    case (ALUSrcA)
      SRCA_OLDPC: SrcA = oldpc_q;
      SRCA_RS1:   SrcA = a_q;
      default:    SrcA = pc_out;
    endcase
  end

  // ALU operand B select.
  always_comb begin
    SrcB = b_q;
    case (ALUSrcB)
      SRCB_IMM:  SrcB = imm_val;
      SRCB_FOUR: SrcB = 32'd4;
      default:   SrcB = b_q;
    endcase
  end

  // Result bus select, feeding PC, register write and memory address.
  always_comb begin
    Result = alu_out;
    case (ResultSrc)
      RES_DATA:   Result = data_q;
      RES_ALURES: Result = alu_res;
      default:    Result = alu_out;
    endcase
  end

  // Datapath registers; PC, IR and OldPC load only when enabled, the rest every cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_out  <= '0;
      ir_out  <= '0;
      oldpc_q <= '0;
      data_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_out <= '0;
    end else begin
      if (PCwrite) pc_out <= Result;
      if (IRWrite) begin
        ir_out  <= mem_bus.rdata;
        oldpc_q <= pc_out;
      end
      data_q  <= mem_bus.rdata;
      a_q     <= rd1;
      b_q     <= rd2;
      alu_out <= alu_res;
    end
  end

endmodule

// File: tb/tb_cpu.sv
// tb/tb_cpu.sv - directed self-checking bench for the multi-cycle cpu
module tb_cpu;
  import cpu_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  cpu #(.MEM_WORDS(256)) dut (
    .clk  (clk),
    .reset(reset)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold_reset_and_clear();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 256; i++) dut.memory.mem[i] = 32'h0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    // Program 1: addi x1,x0,5 then halt
    hold_reset_and_clear();
    dut.memory.mem[0] = 32'h00500093;
    dut.memory.mem[1] = 32'h0000006F;
    @(negedge clk);
    check("rst_pc", dut.pc_out, 32'h0);
    check("rst_ir", dut.ir_out, 32'h0);
    check("rst_aluout", dut.alu_out, 32'h0);
    check("rst_cs", 32'(dut.control_unit.fsm.cs), 32'(S_FETCH));
    check("rst_memwrite", 32'(dut.MemWrite), 32'h0);
    check("rst_regwrite", 32'(dut.RegWrite), 32'h0);
    check("rst_x1", dut.regfile_inst.regs[1], 32'h0);
    release_reset();
    step(3);
    check("addi_x1_early", dut.regfile_inst.regs[1], 32'h0);
    step(1);
    check("addi_x1", dut.regfile_inst.regs[1], 32'h5);
    check("addi_cs_fetch", 32'(dut.control_unit.fsm.cs), 32'(S_FETCH));
    step(8);
    check("halt_pc", dut.pc_out, 32'h4);
    check("halt_ir", dut.ir_out, 32'h0000006F);
    check("halt_x0", dut.regfile_inst.regs[0], 32'h0);

    // Program 2: ALU register and immediate operations
    hold_reset_and_clear();
    dut.memory.mem[0]  = 32'h00500093;  // addi x1,x0,5
    dut.memory.mem[1]  = 32'h00300113;  // addi x2,x0,3
    dut.memory.mem[2]  = 32'h002081B3;  // add  x3,x1,x2
    dut.memory.mem[3]  = 32'h40208433;  // sub  x8,x1,x2
    dut.memory.mem[4]  = 32'h00112233;  // slt  x4,x2,x1
    dut.memory.mem[5]  = 32'hFFF00293;  // addi x5,x0,-1
    dut.memory.mem[6]  = 32'h0012A4B3;  // slt  x9,x5,x1
    dut.memory.mem[7]  = 32'h0050A533;  // slt  x10,x1,x5
    dut.memory.mem[8]  = 32'h0020F5B3;  // and  x11,x1,x2
    dut.memory.mem[9]  = 32'h0020E633;  // or   x12,x1,x2
    dut.memory.mem[10] = 32'h0080E693;  // ori  x13,x1,8
    dut.memory.mem[11] = 32'h0040F713;  // andi x14,x1,4
    dut.memory.mem[12] = 32'h0002A793;  // slti x15,x5,0
    dut.memory.mem[13] = 32'h00700013;  // addi x0,x0,7
    dut.memory.mem[14] = 32'h40008813;  // addi x16,x1,1024
    dut.memory.mem[15] = 32'h0000006F;  // jal  x0,0
    release_reset();
    step(8);
    step(3);
    check("add_x3_early", dut.regfile_inst.regs[3], 32'h0);
    step(1);
    check("add_x3", dut.regfile_inst.regs[3], 32'h8);
    step(4);
    check("sub_x8", dut.regfile_inst.regs[8], 32'h2);
    step(4);
    check("slt_x4", dut.regfile_inst.regs[4], 32'h1);
    step(4);
    check("addi_neg_x5", dut.regfile_inst.regs[5], 32'hFFFFFFFF);
    step(4);
    check("slt_signed_x9", dut.regfile_inst.regs[9], 32'h1);
    step(4);
    check("slt_signed_x10", dut.regfile_inst.regs[10], 32'h0);
    step(4);
    check("and_x11", dut.regfile_inst.regs[11], 32'h1);
    step(4);
    check("or_x12", dut.regfile_inst.regs[12], 32'h7);
    step(4);
    check("ori_x13", dut.regfile_inst.regs[13], 32'hD);
    step(4);
    check("andi_x14", dut.regfile_inst.regs[14], 32'h4);
    step(4);
    check("slti_x15", dut.regfile_inst.regs[15], 32'h1);
    step(4);
    check("addi_x0", dut.regfile_inst.regs[0], 32'h0);
    step(4);
    check("addi_bit30_x16", dut.regfile_inst.regs[16], 32'h405);
    step(4);
    check("prog2_halt_pc", dut.pc_out, 32'd60);

    // Program 3: store, load and address wrap
    hold_reset_and_clear();
    dut.memory.mem[0]  = 32'h00500093;  // addi x1,x0,5
    dut.memory.mem[1]  = 32'h04102023;  // sw   x1,64(x0)
    dut.memory.mem[2]  = 32'h04002303;  // lw   x6,64(x0)
    dut.memory.mem[3]  = 32'h44002883;  // lw   x17,1088(x0) wraps to word 16
    dut.memory.mem[4]  = 32'h0000006F;
    dut.memory.mem[16] = 32'hDEADBEEF;
    release_reset();
    step(4);
    step(3);
    check("sw_mem_early", dut.memory.mem[16], 32'hDEADBEEF);
    check("sw_memwrite", 32'(dut.MemWrite), 32'h1);
    step(1);
    check("sw_mem16", dut.memory.mem[16], 32'h5);
    step(4);
    check("lw_x6_early", dut.regfile_inst.regs[6], 32'h0);
    step(1);
    check("lw_x6", dut.regfile_inst.regs[6], 32'h5);
    step(5);
    check("lw_wrap_x17", dut.regfile_inst.regs[17], 32'h5);

    // Program 4: taken and not-taken beq, jal link
    hold_reset_and_clear();
    dut.memory.mem[0] = 32'h00500093;  // addi x1,x0,5
    dut.memory.mem[1] = 32'h00300113;  // addi x2,x0,3
    dut.memory.mem[2] = 32'h00108463;  // beq  x1,x1,+8
    dut.memory.mem[3] = 32'h00100A13;  // addi x20,x0,1 (skipped)
    dut.memory.mem[4] = 32'h00208463;  // beq  x1,x2,+8
    dut.memory.mem[5] = 32'h00C003EF;  // jal  x7,+12
    dut.memory.mem[6] = 32'h00100A13;  // skipped
    dut.memory.mem[7] = 32'h00100A13;  // skipped
    dut.memory.mem[8] = 32'h0000006F;
    release_reset();
    step(8);
    step(2);
    check("beq_decode_pc", dut.pc_out, 32'd12);
    check("beq_target_aluout", dut.alu_out, 32'd16);
    step(1);
    check("beq_taken_pc", dut.pc_out, 32'd16);
    step(3);
    check("beq_nottaken_pc", dut.pc_out, 32'd20);
    step(3);
    check("jal_pc", dut.pc_out, 32'd32);
    step(1);
    check("jal_x7", dut.regfile_inst.regs[7], 32'd24);
    check("skipped_x20", dut.regfile_inst.regs[20], 32'h0);

    // Program 4b: not-taken beq at PC=8
    reset = 1'b0;
    #1;
    dut.memory.mem[2] = 32'h00208463;  // beq x1,x2,+8
    release_reset();
    step(11);
    check("beq_nt_at8_pc", dut.pc_out, 32'd12);

    // Reset asserted during MEMADR of a store
    hold_reset_and_clear();
    dut.memory.mem[0]  = 32'h00500093;
    dut.memory.mem[1]  = 32'h04102023;
    dut.memory.mem[2]  = 32'h0000006F;
    dut.memory.mem[16] = 32'hDEADBEEF;
    release_reset();
    step(6);
    check("abort_cs_memadr", 32'(dut.control_unit.fsm.cs), 32'(S_MEMADR));
    reset = 1'b0;
    #1;
    check("abort_cs_fetch", 32'(dut.control_unit.fsm.cs), 32'(S_FETCH));
    check("abort_pc", dut.pc_out, 32'h0);
    check("abort_x1", dut.regfile_inst.regs[1], 32'h0);
    step(2);
    check("abort_no_write", dut.memory.mem[16], 32'hDEADBEEF);
    check("abort_memwrite", 32'(dut.MemWrite), 32'h0);
    release_reset();
    step(4);
    check("restart_x1", dut.regfile_inst.regs[1], 32'h5);
    check("restart_pc", dut.pc_out, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
